dds_multichannel_core: RTL

- Parametrised successor to the single-channel DDS: NUM_CH independent phase-accumulator channels sharing one sample-rate divider.
- Each channel has a per-channel frequency tuning word, phase offset and waveform mode (saw/square/triangle/off).
- Configuration goes through a valid/ready write port into shadow registers. A single update strobe commits all shadow registers to the active set on the next sample tick, so frequency and phase changes are glitch-free and simultaneous.
- Sits between the tt_um top-level pin decode and the output mux/DAC pins.

---
 rtl/dds_multichannel_core.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dds_multichannel_core.sv
// dds_multichannel_core: NUM_CH independent phase-accumulator DDS channels
// sharing one sample-rate divider. Configuration lands in shadow registers
// through a valid/ready port; an update strobe commits every channel's shadow
// set to the active set on the next sample tick, so changes apply together.
module dds_multichannel_core #(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 8,
  parameter int DIV_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     sync,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [2:0]               cfg_ch,
  input  logic [1:0]               cfg_addr,
  input  logic [ACC_W-1:0]         cfg_data,
  input  logic                     update,
  output logic [NUM_CH*OUT_W-1:0]  wave_out,
  output logic                     tick_out
);

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ADDR_FTW  = 2'd0,
    ADDR_OFF  = 2'd1,
    ADDR_MODE = 2'd2,
    ADDR_DIV  = 2'd3
  } addr_e;

  // One channel's configuration; shadow and active copies share this layout.
  typedef struct packed {
    logic [ACC_W-1:0] ftw;
    logic [ACC_W-1:0] off;
    mode_e            mode;
  } ch_cfg_t;

  ch_cfg_t                 shadow_q [NUM_CH];
  ch_cfg_t                 shadow_d [NUM_CH];
  ch_cfg_t                 active_q [NUM_CH];
  ch_cfg_t                 active_d [NUM_CH];
  logic [ACC_W-1:0]        acc_q    [NUM_CH];
  logic [ACC_W-1:0]        acc_d    [NUM_CH];
  logic [DIV_W-1:0]        div_q, div_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic                    pending_q, pending_d;
  logic                    sample_q, sample_d;
  logic                    tick_q, tick_d;
  logic [NUM_CH*OUT_W-1:0] wave_q, wave_d;

  logic tick;
  logic commit;
  logic accept;

  // Maps a phase word to an output sample for the selected waveform.
  function automatic logic [OUT_W-1:0] shape(input logic [ACC_W-1:0] p,
                                             input mode_e            mode);
    logic [OUT_W-1:0] t;
    logic [OUT_W-1:0] u;
    t = p[ACC_W-1 -: OUT_W];
    u = {t[OUT_W-2:0], 1'b0};
    case (mode)
      MODE_SAW:    shape = t;
      MODE_SQUARE: shape = {OUT_W{p[ACC_W-1]}};
      MODE_TRI:    shape = p[ACC_W-1] ? ~u : u;
      default:     shape = '0;
    endcase
  endfunction

  // Handshake is blocked while a commit is outstanding and during reset.
  assign cfg_ready = !pending_q && !rst;

  // Sample tick, commit qualifier and write acceptance.
  always_comb begin
    tick   = en && (cnt_q >= div_q);
    commit = pending_q && tick && !sync;
    accept = cfg_valid && cfg_ready;
  end

  // Next-state for divider, config, accumulators and the two-stage output.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    div_d     = div_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    acc_d     = acc_q;
    wave_d    = wave_q;
    sample_d  = tick || sync;
    tick_d    = sample_q;

    if (accept) begin
      if (cfg_addr == ADDR_DIV) begin
        div_d = DIV_W'(cfg_data);
      end else begin
        // Out-of-range channels match no iteration, so the write is dropped.
        for (int c = 0; c < NUM_CH; c++) begin
          if (cfg_ch == 3'(c)) begin
            case (cfg_addr)
              ADDR_FTW:  shadow_d[c].ftw  = cfg_data;
              ADDR_OFF:  shadow_d[c].off  = cfg_data;
              ADDR_MODE: shadow_d[c].mode = mode_e'(cfg_data[1:0]);
              default:   ;
            endcase
          end
        end
      end
    end

    if (update) pending_d = 1'b1;
    if (commit) begin
      pending_d = 1'b0;
      active_d  = shadow_q;
    end

    // Sync wins over tick: it realigns phase and swallows that accumulate.
    if (sync) begin
      cnt_d = '0;
      for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
    end else if (tick) begin
      cnt_d = '0;
      for (int c = 0; c < NUM_CH; c++)
        acc_d[c] = acc_q[c] + (commit ? shadow_q[c].ftw : active_q[c].ftw);
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    // Second stage: shape the freshly updated accumulators one cycle later.
    if (sample_q) begin
      for (int c = 0; c < NUM_CH; c++)
        wave_d[c*OUT_W +: OUT_W] = shape(acc_q[c] + active_q[c].off,
                                         active_q[c].mode);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-channel arrays are cleared explicitly; reset must leave
      // every channel's shadow, active set and accumulator at zero.
      for (int c = 0; c < NUM_CH; c++) begin
        shadow_q[c] <= '0;
        active_q[c] <= '0;
        acc_q[c]    <= '0;
      end
      div_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      sample_q  <= 1'b0;
      tick_q    <= 1'b0;
      wave_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      acc_q     <= acc_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      sample_q  <= sample_d;
      tick_q    <= tick_d;
      wave_q    <= wave_d;
    end
  end

  assign wave_out = wave_q;
  assign tick_out = tick_q;

endmodule
